// File: rtl/vc_alloc_controller_pkg.sv
// vc_alloc_pkg: shared index types, default sizes and the dateline target-VC rule.
package vc_alloc_pkg;
  localparam int DEF_INPORTS  = 5;
  localparam int DEF_OUTPORTS = 5;
  localparam int DEF_VCS      = 2;
  typedef logic [$clog2(DEF_INPORTS)-1:0]  inport_t;
  typedef logic [$clog2(DEF_OUTPORTS)-1:0] outport_t;
  typedef logic [$clog2(DEF_VCS)-1:0]      vc_t;
  function automatic int target_vc(input int vc, input int num_vcs, input logic dl);
    return dl ? ((vc + 1 < num_vcs - 1) ? vc + 1 : num_vcs - 1) : vc;
  endfunction
endpackage

// File: rtl/vc_alloc_controller_if.sv
// vc_alloc_controller_if: request/grant/release bundle between routers and the VC allocator.
interface vc_alloc_controller_if #(
  parameter int NUM_INPORTS  = 5,
  parameter int NUM_OUTPORTS = 5,
  parameter int NUM_VCS      = 2
);
  localparam int VW = NUM_VCS > 1 ? $clog2(NUM_VCS) : 1;
  localparam int OW = NUM_OUTPORTS > 1 ? $clog2(NUM_OUTPORTS) : 1;
  logic [NUM_INPORTS-1:0]               req;
  logic [NUM_INPORTS-1:0][VW-1:0]       req_vc;
  logic [NUM_INPORTS-1:0][OW-1:0]       req_outport;
  logic [NUM_OUTPORTS-1:0]              dateline;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0] vc_release;
  logic [NUM_INPORTS-1:0]               grant;
  logic [VW-1:0]                        grant_vc;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0] vc_busy;
  logic                                 release_err;
  modport master (output req, req_vc, req_outport, dateline, vc_release,
                  input grant, grant_vc, vc_busy, release_err);
  modport slave  (input req, req_vc, req_outport, dateline, vc_release,
                  output grant, grant_vc, vc_busy, release_err);
endinterface

// File: rtl/vc_alloc_controller_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from i_ptr with wrap.
module rr_arbiter #(
  parameter int N = 5
) (
  input  logic [N-1:0]                     i_elig,
  input  logic [(N > 1 ? $clog2(N) : 1)-1:0] i_ptr,
  output logic [N-1:0]                     o_win,
  output logic                             o_valid
);
  assign o_valid = |i_elig;
  always_comb begin
    o_win = '0;
    for (int k = 0; k < N; k++)
      if (o_win == '0 && i_elig[(int'(i_ptr) + k) % N]) o_win[(int'(i_ptr) + k) % N] = 1'b1;
  end
endmodule

// File: rtl/vc_alloc_controller.sv
// vc_alloc_controller: one round-robin output-VC grant per cycle with a registered ownership table.
module vc_alloc_controller
  import vc_alloc_pkg::*;
#(
  parameter int NUM_INPORTS  = DEF_INPORTS,
  parameter int NUM_OUTPORTS = DEF_OUTPORTS,
  parameter int NUM_VCS      = DEF_VCS
) (
  input logic CLK,
  input logic nRST,
  vc_alloc_controller_if.slave bus
);
  localparam int VW = NUM_VCS > 1 ? $clog2(NUM_VCS) : 1;
  localparam int PW = NUM_INPORTS > 1 ? $clog2(NUM_INPORTS) : 1;
  logic [NUM_INPORTS-1:0][VW-1:0]       w_tgt;
  logic [NUM_INPORTS-1:0]               w_op_ok, w_elig, w_win;
  logic                                 w_valid;
  logic [PW-1:0]                        w_win_idx;
  logic [VW-1:0]                        w_win_vc;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0] w_set;
  logic [NUM_INPORTS-1:0]               r_grant;
  logic [VW-1:0]                        r_grant_vc;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0] r_vc_busy;
  logic                                 r_release_err;
  logic [PW-1:0]                        r_rr_ptr;
  // Inports currently on grant are masked so a req held through its grant cycle is not re-won.
  always_comb begin
    w_op_ok = '0;
    w_tgt   = '0;
    w_elig  = '0;
    for (int i = 0; i < NUM_INPORTS; i++) begin
      w_op_ok[i] = int'(bus.req_outport[i]) < NUM_OUTPORTS;
      w_tgt[i]   = VW'(target_vc(int'(bus.req_vc[i]), NUM_VCS,
                                 w_op_ok[i] ? bus.dateline[bus.req_outport[i]] : 1'b0));
      w_elig[i]  = bus.req[i] && !r_grant[i] && w_op_ok[i] &&
                   !r_vc_busy[bus.req_outport[i]][w_tgt[i]];
    end
  end
  rr_arbiter #(.N(NUM_INPORTS)) u_arb (
    .i_elig (w_elig),
    .i_ptr  (r_rr_ptr),
    .o_win  (w_win),
    .o_valid(w_valid)
  );
  always_comb begin
    w_win_idx = '0;
    w_win_vc  = '0;
    w_set     = '0;
    for (int i = 0; i < NUM_INPORTS; i++)
      if (w_win[i]) begin
        w_win_idx = PW'(i);
        w_win_vc  = w_tgt[i];
        w_set[bus.req_outport[i]][w_tgt[i]] = 1'b1;
      end
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      r_grant       <= '0;
      r_grant_vc    <= '0;
      r_vc_busy     <= '0;
      r_release_err <= 1'b0;
      r_rr_ptr      <= '0;
    end else begin
      r_grant       <= w_win;
      r_grant_vc    <= w_win_vc;
      r_vc_busy     <= (r_vc_busy & ~bus.vc_release) | w_set;
      r_release_err <= r_release_err | (|(~r_vc_busy & bus.vc_release));
      if (w_valid) r_rr_ptr <= (w_win_idx == PW'(NUM_INPORTS - 1)) ? '0 : w_win_idx + 1'b1;
    end
  assign bus.grant       = r_grant;
  assign bus.grant_vc    = r_grant_vc;
  assign bus.vc_busy     = r_vc_busy;
  assign bus.release_err = r_release_err;
endmodule

// File: tb/tb_vc_alloc_controller.sv
// tb_vc_alloc_controller: directed scenarios with hand-computed grants and ownership tables.
module tb_vc_alloc_controller;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   errs = 0;
  int   checks = 0;
  always #5 CLK = ~CLK;
  vc_alloc_controller_if #(.NUM_INPORTS(5), .NUM_OUTPORTS(5), .NUM_VCS(2)) bus ();
  vc_alloc_controller #(.NUM_INPORTS(5), .NUM_OUTPORTS(5), .NUM_VCS(2)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic idle;
    bus.req         = '0;
    bus.req_vc      = '0;
    bus.req_outport = '0;
    bus.dateline    = '0;
    bus.vc_release  = '0;
  endtask
  task automatic do_reset;
    nRST = 1'b0;
    #1;
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_gvc", 32'(bus.grant_vc), 0);
    check("rst_busy", 32'(bus.vc_busy), 0);
    check("rst_err", 32'(bus.release_err), 0);
    check("rst_ptr", 32'(dut.r_rr_ptr), 0);
    @(posedge CLK);
    #1 nRST = 1'b1;
  endtask
  initial begin
    idle();
    do_reset();
    // single requester, no dateline
    bus.req[0] = 1'b1; bus.req_vc[0] = 1'b0; bus.req_outport[0] = 3'd2;
    tick();
    check("s1_grant", 32'(bus.grant), 32'h01);
    check("s1_gvc", 32'(bus.grant_vc), 0);
    check("s1_busy", 32'(bus.vc_busy), 32'h010);
    bus.req[0] = 1'b0;
    tick();
    check("s1_idle", 32'(bus.grant), 0);
    // dateline bump, then saturation
    bus.dateline[3] = 1'b1;
    bus.req[1] = 1'b1; bus.req_vc[1] = 1'b0; bus.req_outport[1] = 3'd3;
    tick();
    check("s2_grant", 32'(bus.grant), 32'h02);
    check("s2_gvc", 32'(bus.grant_vc), 1);
    check("s2_busy", 32'(bus.vc_busy), 32'h090);
    bus.req[1] = 1'b0; bus.vc_release[3][1] = 1'b1;
    tick();
    bus.vc_release = '0;
    check("s2_rel", 32'(bus.vc_busy), 32'h010);
    check("s2_err", 32'(bus.release_err), 0);
    bus.req[1] = 1'b1; bus.req_vc[1] = 1'b1;
    tick();
    check("s2_sat_grant", 32'(bus.grant), 32'h02);
    check("s2_sat_gvc", 32'(bus.grant_vc), 1);
    check("s2_sat_busy", 32'(bus.vc_busy), 32'h090);
    bus.req[1] = 1'b0; bus.vc_release[3][1] = 1'b1; bus.vc_release[2][0] = 1'b1;
    tick();
    idle();
    check("s2_multi_rel", 32'(bus.vc_busy), 0);
    check("s2_err2", 32'(bus.release_err), 0);
    check("s2_nogrant", 32'(bus.grant), 0);
    // three held requesters, round robin with wrap
    do_reset();
    bus.req = 5'b10101;
    bus.req_outport[0] = 3'd0; bus.req_outport[2] = 3'd1; bus.req_outport[4] = 3'd4;
    tick();
    check("s3_g0", 32'(bus.grant), 32'h01);
    check("s3_ptr1", 32'(dut.r_rr_ptr), 1);
    tick();
    check("s3_g2", 32'(bus.grant), 32'h04);
    tick();
    check("s3_g4", 32'(bus.grant), 32'h10);
    check("s3_wrap", 32'(dut.r_rr_ptr), 0);
    tick();
    check("s3_done", 32'(bus.grant), 0);
    check("s3_busy", 32'(bus.vc_busy), 32'h105);
    idle();
    // contention on outport 0 VC 0
    do_reset();
    bus.req = 5'b01010;
    tick();
    check("s4_win", 32'(bus.grant), 32'h02);
    bus.req[1] = 1'b0;
    tick();
    check("s4_lose1", 32'(bus.grant), 0);
    tick();
    check("s4_lose2", 32'(bus.grant), 0);
    bus.vc_release[0][0] = 1'b1;
    tick();
    check("s4_relcyc", 32'(bus.grant), 0);
    check("s4_cleared", 32'(bus.vc_busy), 0);
    bus.vc_release = '0;
    tick();
    check("s4_regrant", 32'(bus.grant), 32'h08);
    check("s4_gvc", 32'(bus.grant_vc), 0);
    check("s4_busy", 32'(bus.vc_busy), 32'h001);
    idle();
    bus.req[2] = 1'b1; bus.req_outport[2] = 3'd5;
    tick();
    tick();
    check("s4_oor_grant", 32'(bus.grant), 0);
    check("s4_oor_busy", 32'(bus.vc_busy), 32'h001);
    idle();
    // release on a free entry
    do_reset();
    bus.vc_release[4][1] = 1'b1;
    tick();
    bus.vc_release = '0;
    check("s5_err", 32'(bus.release_err), 1);
    check("s5_busy", 32'(bus.vc_busy), 0);
    tick();
    tick();
    check("s5_sticky", 32'(bus.release_err), 1);
    check("s5_busy2", 32'(bus.vc_busy), 0);
    // async reset during a grant cycle
    bus.req[0] = 1'b1; bus.req_outport[0] = 3'd2;
    tick();
    check("s6_grant", 32'(bus.grant), 32'h01);
    bus.req[0] = 1'b0;
    #2 nRST = 1'b0;
    #1;
    check("s6_grant0", 32'(bus.grant), 0);
    check("s6_busy0", 32'(bus.vc_busy), 0);
    check("s6_ptr0", 32'(dut.r_rr_ptr), 0);
    check("s6_err0", 32'(bus.release_err), 0);
    nRST = 1'b1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
